// File: rtl/onewire_master.sv
// rtl/onewire_master.sv - 1-Wire bus master: reset/presence, write byte, read byte over a us-tick slot engine
// Optional Dallas CRC-8 accumulator on o_crc when ONEWIRE_CRC_EN is defined.
module onewire_master #(
    parameter int US_DIV      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_cmd,
    input  logic [7:0] i_wdata,
    input  logic       i_cmd_valid,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic       o_presence,
    output logic [7:0] o_crc,
    input  logic       i_owr,
    output logic       o_owr
);

    localparam int PW = (US_DIV > 1) ? $clog2(US_DIV) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RST_LOW   = 3'd1;
    localparam logic [2:0] S_RST_WAIT  = 3'd2;
    localparam logic [2:0] S_RST_REC   = 3'd3;
    localparam logic [2:0] S_SLOT_LOW  = 3'd4;
    localparam logic [2:0] S_SLOT_HOLD = 3'd5;
    localparam logic [2:0] S_SLOT_REC  = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    localparam logic [1:0] CMD_RST = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_RD  = 2'b11;

    logic [2:0]             state;
    logic [PW-1:0]          presc;
    logic [8:0]             us_cnt;
    logic [8:0]             phase_len;
    logic [1:0]             cmd;
    logic [7:0]             shreg;
    logic [2:0]             bit_idx;
    logic [SYNC_STAGES-1:0] sync;
    logic                   bus_s;
    logic                   tick;
    logic                   phase_end;
    logic                   accept;
    logic                   wr_zero;
    logic                   sample_rd;

    assign bus_s     = sync[SYNC_STAGES-1];
    assign tick      = (presc == PW'(US_DIV - 1));
    assign phase_end = tick && (us_cnt == phase_len - 9'd1);
    assign accept    = (state == S_IDLE) && i_cmd_valid && !o_busy && (i_cmd != 2'b00);
    assign wr_zero   = (cmd == CMD_WR) && !shreg[0];
    // Read slots sample at the end of the 9th microsecond of the hold phase
    assign sample_rd = (state == S_SLOT_HOLD) && (cmd == CMD_RD) && tick && (us_cnt == 9'd8);

    always_comb begin
        phase_len = 9'd1;
        case (state)
            S_RST_LOW:   phase_len = 9'd480;
            S_RST_WAIT:  phase_len = 9'd70;
            S_RST_REC:   phase_len = 9'd410;
            S_SLOT_LOW:  phase_len = wr_zero ? 9'd60 : 9'd6;
            S_SLOT_HOLD: phase_len = 9'd54;
            S_SLOT_REC:  phase_len = 9'd10;
            default:     phase_len = 9'd1;
        endcase
    end

`ifdef ONEWIRE_CRC_EN
    logic [7:0] crc;
    logic       crc_en;
    logic       crc_bit;
    logic       crc_clr;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic [7:0] n;
        n = c >> 1;
        if (c[0] ^ b) n = n ^ 8'h8C;
        return n;
    endfunction

    assign crc_clr = accept && (i_cmd == CMD_RST);
    assign crc_en  = sample_rd || ((state == S_SLOT_REC) && (cmd == CMD_WR) && phase_end);
    assign crc_bit = (cmd == CMD_RD) ? bus_s : shreg[0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)        crc <= 8'h00;
        else if (crc_clr) crc <= 8'h00;
        else if (crc_en)  crc <= crc_step(crc, crc_bit);
    end

    assign o_crc = crc;
`else
    assign o_crc = 8'h00;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            presc      <= '0;
            us_cnt     <= 9'd0;
            cmd        <= 2'b00;
            shreg      <= 8'h00;
            bit_idx    <= 3'd0;
            sync       <= '1;
            o_owr      <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_rdata    <= 8'h00;
            o_presence <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], i_owr};
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cmd     <= i_cmd;
                        shreg   <= i_wdata;
                        bit_idx <= 3'd0;
                        presc   <= '0;
                        us_cnt  <= 9'd0;
                        o_busy  <= 1'b1;
                        o_owr   <= 1'b1;
                        state   <= (i_cmd == CMD_RST) ? S_RST_LOW : S_SLOT_LOW;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    if (phase_end) begin
                        presc  <= '0;
                        us_cnt <= 9'd0;
                    end else if (tick) begin
                        presc  <= '0;
                        us_cnt <= us_cnt + 9'd1;
                    end else begin
                        presc  <= presc + PW'(1);
                    end
                    if (sample_rd) shreg <= {bus_s, shreg[7:1]};
                    if (phase_end) begin
                        case (state)
                            S_RST_LOW: begin
                                o_owr <= 1'b0;
                                state <= S_RST_WAIT;
                            end
                            S_RST_WAIT: begin
                                o_presence <= ~bus_s;
                                state      <= S_RST_REC;
                            end
                            S_RST_REC: begin
                                o_busy <= 1'b0;
                                o_done <= 1'b1;
                                state  <= S_DONE;
                            end
                            S_SLOT_LOW: begin
                                o_owr <= 1'b0;
                                state <= wr_zero ? S_SLOT_REC : S_SLOT_HOLD;
                            end
                            S_SLOT_HOLD: state <= S_SLOT_REC;
                            S_SLOT_REC: begin
                                if (bit_idx == 3'd7) begin
                                    if (cmd == CMD_RD) o_rdata <= shreg;
                                    o_busy <= 1'b0;
                                    o_done <= 1'b1;
                                    state  <= S_DONE;
                                end else begin
                                    bit_idx <= bit_idx + 3'd1;
                                    if (cmd == CMD_WR) shreg <= shreg >> 1;
                                    o_owr   <= 1'b1;
                                    state   <= S_SLOT_LOW;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onewire_master.sv
// tb/tb_onewire_master.sv - randomized self-checking bench for onewire_master with a behavioural bus/device model
module tb_onewire_master;
    localparam int US = 4;
`ifdef ONEWIRE_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [1:0] i_cmd = 2'b00;
    logic [7:0] i_wdata = 8'h00;
    logic       i_cmd_valid = 1'b0;
    logic       o_busy, o_done, o_presence, o_owr, i_owr;
    logic [7:0] o_rdata, o_crc;
    logic       device_pull = 1'b0;

    onewire_master #(.US_DIV(US), .SYNC_STAGES(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cmd(i_cmd), .i_wdata(i_wdata),
        .i_cmd_valid(i_cmd_valid), .o_busy(o_busy), .o_done(o_done),
        .o_rdata(o_rdata), .o_presence(o_presence), .o_crc(o_crc),
        .i_owr(i_owr), .o_owr(o_owr)
    );

    // Open-drain bus: low if master or device pulls
    assign i_owr = ~(o_owr | device_pull);

    always #5 i_clk = ~i_clk;

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, acc_cyc = 0;
    int lows[$];
    int lowcnt = 0, done_cnt = 0;
    bit dev_present = 1'b1, read_mode = 1'b0;
    bit rd_bits[$];
    logic [7:0] model_crc = 8'h00;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_done === 1'b1) done_cnt++;
        if (o_owr === 1'b1) lowcnt++;
        else if (lowcnt != 0) begin
            lows.push_back(lowcnt);
            lowcnt = 0;
        end
    end

    initial begin : device
        int t0, st, du;
        bit b;
        forever begin
            @(posedge o_owr);
            if (read_mode) begin
                if (rd_bits.size() > 0) begin
                    b = rd_bits.pop_front();
                    if (!b) begin
                        device_pull = 1'b1;
                        repeat (30 * US) @(negedge i_clk);
                        device_pull = 1'b0;
                    end
                end
            end else begin
                t0 = cyc;
                @(negedge o_owr);
                if (dev_present && (cyc - t0) >= 400 * US) begin
                    st = $urandom_range(15, 30);
                    du = $urandom_range(60, 120);
                    repeat (st * US) @(negedge i_clk);
                    device_pull = 1'b1;
                    repeat (du * US) @(negedge i_clk);
                    device_pull = 1'b0;
                end
            end
        end
    end

    function automatic logic [7:0] crc_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 8'h8C;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic issue(input logic [1:0] c, input logic [7:0] d);
        @(negedge i_clk);
        lows.delete();
        lowcnt = 0;
        done_cnt = 0;
        i_cmd = c;
        i_wdata = d;
        i_cmd_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        acc_cyc = cyc;
        i_cmd_valid = 1'b0;
        i_cmd = 2'($urandom);
        i_wdata = 8'($urandom);
    endtask

    task automatic wait_done(input int budget, output int lat);
        int n;
        n = 0;
        while (o_done !== 1'b1 && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        lat = (o_done === 1'b1) ? cyc - acc_cyc : -1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge i_clk);
        n_cmp++;
        if ({o_owr, o_busy, o_done, o_presence, o_rdata, o_crc} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %b required 0", {o_owr, o_busy, o_done, o_presence, o_rdata, o_crc});
        end
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_presence(input bit present);
        int lat;
        dev_present = present;
        issue(2'b01, 8'h00);
        model_crc = 8'h00;
        n_cmp++;
        if (o_busy !== 1'b1) begin n_fail++; $display("FAIL presence_busy_rise: got %b required 1", o_busy); end
        wait_done(5000, lat);
        n_cmp++;
        if (lat !== 960 * US) begin n_fail++; $display("FAIL presence_latency: got %0d required %0d", lat, 960 * US); end
        n_cmp++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL presence_busy_at_done: got %b required 0", o_busy); end
        n_cmp++;
        if (o_presence !== present) begin n_fail++; $display("FAIL presence_result: got %b required %b", o_presence, present); end
        n_cmp++;
        if (lows.size() !== 1 || lows[0] !== 480 * US) begin
            n_fail++;
            $display("FAIL presence_low_width: got n=%0d w=%0d required n=1 w=%0d", lows.size(), (lows.size() > 0) ? lows[0] : -1, 480 * US);
        end
        repeat (5) @(negedge i_clk);
        n_cmp++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL presence_done_pulses: got %0d required 1", done_cnt); end
    endtask

    task automatic test_write(input logic [7:0] b);
        int lat, w;
        issue(2'b10, b);
        model_crc = crc_byte(model_crc, b);
        wait_done(3000, lat);
        n_cmp++;
        if (lat !== 8 * 70 * US) begin n_fail++; $display("FAIL write_latency %h: got %0d required %0d", b, lat, 8 * 70 * US); end
        n_cmp++;
        if (lows.size() !== 8) begin n_fail++; $display("FAIL write_slot_count %h: got %0d required 8", b, lows.size()); end
        for (int i = 0; i < 8 && i < lows.size(); i++) begin
            w = b[i] ? 6 * US : 60 * US;
            n_cmp++;
            if (lows[i] !== w) begin n_fail++; $display("FAIL write_low_width %h bit%0d: got %0d required %0d", b, i, lows[i], w); end
        end
        n_cmp++;
        if (o_crc !== (CRC_EN ? model_crc : 8'h00)) begin
            n_fail++;
            $display("FAIL write_crc %h: got %h required %h", b, o_crc, CRC_EN ? model_crc : 8'h00);
        end
    endtask

    task automatic test_read(input logic [7:0] b);
        int lat;
        rd_bits.delete();
        for (int i = 0; i < 8; i++) rd_bits.push_back(b[i]);
        read_mode = 1'b1;
        issue(2'b11, 8'($urandom));
        model_crc = crc_byte(model_crc, b);
        wait_done(3000, lat);
        n_cmp++;
        if (o_rdata !== b) begin n_fail++; $display("FAIL read_data: got %h required %h", o_rdata, b); end
        n_cmp++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_at_done: got %b required 0", o_busy); end
        n_cmp++;
        if (lat !== 8 * 70 * US) begin n_fail++; $display("FAIL read_latency %h: got %0d required %0d", b, lat, 8 * 70 * US); end
        n_cmp++;
        if (o_crc !== (CRC_EN ? model_crc : 8'h00)) begin
            n_fail++;
            $display("FAIL read_crc %h: got %h required %h", b, o_crc, CRC_EN ? model_crc : 8'h00);
        end
        read_mode = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_ignore();
        @(negedge i_clk);
        lows.delete();
        i_cmd = 2'b00;
        i_cmd_valid = 1'b1;
        repeat (20) @(negedge i_clk);
        n_cmp++;
        if (o_busy !== 1'b0 || lows.size() !== 0 || o_owr !== 1'b0) begin
            n_fail++;
            $display("FAIL cmd00_ignored: got busy=%b pulses=%0d required busy=0 pulses=0", o_busy, lows.size());
        end
        i_cmd_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [7:0] b, obs;
        b = 8'($urandom);
        @(negedge i_clk);
        lows.delete();
        lowcnt = 0;
        done_cnt = 0;
        i_cmd = 2'b10;
        i_wdata = b;
        i_cmd_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        acc_cyc = cyc;
        repeat (1000) begin
            @(negedge i_clk);
            i_wdata = 8'($urandom);
        end
        i_cmd_valid = 1'b0;
        model_crc = crc_byte(model_crc, b);
        wait_done(2000, lat);
        n_cmp++;
        if (lat !== 8 * 70 * US) begin n_fail++; $display("FAIL hold_latency: got %0d required %0d", lat, 8 * 70 * US); end
        repeat (20) @(negedge i_clk);
        n_cmp++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL hold_done_pulses: got %0d required 1", done_cnt); end
        obs = 8'h00;
        for (int i = 0; i < 8 && i < lows.size(); i++) obs[i] = (lows[i] == 6 * US);
        n_cmp++;
        if (lows.size() !== 8 || obs !== b) begin
            n_fail++;
            $display("FAIL hold_captured_byte: got %h (n=%0d) required %h", obs, lows.size(), b);
        end
    endtask

    task automatic test_reset_midslot();
        issue(2'b10, 8'h00);
        repeat (100) @(negedge i_clk);
        n_cmp++;
        if (o_owr !== 1'b1 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midslot_pre: got owr=%b busy=%b required 1 1", o_owr, o_busy);
        end
        i_rst = 1'b1;
        #1;
        n_cmp++;
        if (o_owr !== 1'b0) begin n_fail++; $display("FAIL midslot_owr_release: got %b required 0", o_owr); end
        n_cmp++;
        if ({o_busy, o_done, o_presence, o_rdata, o_crc} !== 19'h0) begin
            n_fail++;
            $display("FAIL midslot_outputs: got %b required 0", {o_busy, o_done, o_presence, o_rdata, o_crc});
        end
        model_crc = 8'h00;
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
    endtask

`ifdef ONEWIRE_CRC_EN
    task automatic test_crc();
        logic [7:0] sp[9];
        int idx;
        sp = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
        test_presence(1'b1);
        for (int i = 0; i < 9; i++) test_read(sp[i]);
        n_cmp++;
        if (o_crc !== 8'h00) begin n_fail++; $display("FAIL crc_scratchpad_valid: got %h required 00", o_crc); end
        idx = $urandom_range(0, 8);
        sp[idx] = sp[idx] ^ 8'($urandom_range(1, 255));
        test_presence(1'b1);
        for (int i = 0; i < 9; i++) test_read(sp[i]);
        n_cmp++;
        if (o_crc === 8'h00) begin n_fail++; $display("FAIL crc_corrupt_detect: got %h required nonzero", o_crc); end
    endtask
`endif

    initial begin
        test_reset();
        test_presence(1'b0);
        test_presence(1'b1);
        test_write(8'hCC);
        test_write(8'($urandom));
        test_write(8'($urandom));
        test_read(8'h50);
        test_read(8'($urandom));
        test_read(8'($urandom));
        test_ignore();
        test_back_to_back();
`ifdef ONEWIRE_CRC_EN
        test_crc();
`endif
        test_reset_midslot();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
